// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M/RV64M multiply/divide unit for the EX stage.
//   A radix-2 shift-add multiply or a restoring divide runs for XLEN cycles.
//   The IF/ID/EX stages stall on busyE. The result is presented with a
//   one-cycle doneE pulse. Latency is fixed at XLEN+3 cycles from accept.
//
// Ports
//   clk      in   1     rising-edge clock
//   reset    in   1     asynchronous active-high reset
//   startE   in   1     valid M op in EX this cycle
//   funct3E  in   3     MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
//   srcaE    in   XLEN  rs1 (multiplicand / dividend)
//   srcbE    in   XLEN  rs2 (multiplier / divisor)
//   flushE   in   1     kill the in-flight op, priority over startE
//   busyE    out  1     stall request (combinational)
//   doneE    out  1     resultE valid this cycle (registered pulse)
//   resultE  out  XLEN  result (registered, held until next op completes)
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            startE,
  input  logic [2:0]      funct3E,
  input  logic [XLEN-1:0] srcaE,
  input  logic [XLEN-1:0] srcbE,
  input  logic            flushE,
  output logic            busyE,
  output logic            doneE,
  output logic [XLEN-1:0] resultE
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

  state_t            r_state;
  logic [2:0]        r_f3;
  logic [XLEN-1:0]   r_opa;     // raw operands, latched at accept
  logic [XLEN-1:0]   r_opb;
  logic [XLEN-1:0]   r_m;       // |a| (multiplicand) for mul, |b| (divisor) for div
  logic [XLEN-1:0]   r_hi;      // product high half / partial remainder
  logic [XLEN-1:0]   r_mq;      // multiplier -> product low half / dividend -> quotient
  logic [CW-1:0]     r_cnt;
  logic              r_neg;
  logic              r_div0;

  // Operand decode (valid once operands are latched)
  logic              w_is_div, w_sa, w_sb, w_an, w_bn, w_neg;
  logic [XLEN-1:0]   w_absa, w_absb;

  assign w_is_div = r_f3[2];
  assign w_sa     = (r_f3 == 3'b001) || (r_f3 == 3'b010) || (r_f3[2] && !r_f3[0]);
  assign w_sb     = (r_f3 == 3'b001) || (r_f3[2] && !r_f3[0]);
  assign w_an     = w_sa && r_opa[XLEN-1];
  assign w_bn     = w_sb && r_opb[XLEN-1];
  assign w_absa   = w_an ? (~r_opa + 1'b1) : r_opa;
  assign w_absb   = w_bn ? (~r_opb + 1'b1) : r_opb;
  // Remainder takes the dividend's sign; product/quotient take the sign xor.
  assign w_neg    = (w_is_div && r_f3[1]) ? w_an : (w_an ^ w_bn);

  // Multiply step: conditional add into the high half, then shift {sum, lo} right.
  logic [XLEN:0]     w_sum;
  assign w_sum = {1'b0, r_hi} + (r_mq[0] ? {1'b0, r_m} : '0);

  // Restoring-divide step with an XLEN+1-bit partial remainder; the top bit of
  // the difference is the borrow, i.e. "divisor did not fit".
  logic [XLEN:0]     w_sh, w_diff;
  assign w_sh   = {r_hi, r_mq[XLEN-1]};
  assign w_diff = w_sh - {1'b0, r_m};

  // Fix-up: signed results and output selection
  logic [2*XLEN-1:0] w_prod, w_prod_f;
  logic [XLEN-1:0]   w_q_f, w_r_f, w_res;
  assign w_prod   = {r_hi, r_mq};
  assign w_prod_f = r_neg ? (~w_prod + 1'b1) : w_prod;
  assign w_q_f    = r_neg ? (~r_mq + 1'b1) : r_mq;
  assign w_r_f    = r_neg ? (~r_hi + 1'b1) : r_hi;

  always_comb begin
    w_res = '0;
    case (r_f3)
      3'b000:                 w_res = w_prod_f[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_res = w_prod_f[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_res = r_div0 ? '1 : w_q_f;
      default:                w_res = r_div0 ? r_opa : w_r_f;
    endcase
  end

  assign busyE = (startE && !flushE && (r_state == S_IDLE || r_state == S_DONE)) ||
                 (r_state == S_PREP) || (r_state == S_CALC) || (r_state == S_FIX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_f3    <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_m     <= '0;
      r_hi    <= '0;
      r_mq    <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_div0  <= 1'b0;
      doneE   <= 1'b0;
      resultE <= '0;
    end else if (flushE) begin
      r_state <= S_IDLE;
      doneE   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          doneE <= 1'b0;
          if (startE) begin
            r_f3    <= funct3E;
            r_opa   <= srcaE;
            r_opb   <= srcbE;
            r_state <= S_PREP;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_PREP: begin
          r_neg   <= w_neg;
          r_div0  <= (r_opb == '0);
          r_hi    <= '0;
          r_m     <= w_is_div ? w_absb : w_absa;
          r_mq    <= w_is_div ? w_absa : w_absb;
          r_cnt   <= CW'(XLEN-1);
          r_state <= S_CALC;
        end
        S_CALC: begin
          if (w_is_div) begin
            r_hi <= w_diff[XLEN] ? w_sh[XLEN-1:0] : w_diff[XLEN-1:0];
            r_mq <= {r_mq[XLEN-2:0], ~w_diff[XLEN]};
          end else begin
            r_hi <= w_sum[XLEN:1];
            r_mq <= {w_sum[0], r_mq[XLEN-1:1]};
          end
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) r_state <= S_FIX;
        end
        S_FIX: begin
          resultE <= w_res;
          doneE   <= 1'b1;
          r_state <= S_DONE;
        end
        default: begin
          doneE   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
